// File: rtl/complex_exec_ctrl.sv
// complex_exec_ctrl: sequences one complex-nibble instruction at a time.
// Each instruction reads two operands from data memory, computes add/sub/mul
// on packed {re, im} 4-bit two's-complement nibbles, and writes the result.
// State machine: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE.
// The reserved opcode skips WRITE and raises a sticky error flag.
module complex_exec_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [2+3*ADDR_W-1:0] instr,
  output logic                  instr_ready,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_rd_addr1,
  output logic [ADDR_W-1:0]     mem_rd_addr2,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  input  logic [7:0]            mem_rd_data1,
  input  logic [7:0]            mem_rd_data2,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            result,
  output logic [7:0]            op_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WRITE,
    DONE
  } state_t;

  state_t            state_reg;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] src_a_reg;
  logic [ADDR_W-1:0] src_b_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [7:0]        result_reg;
  logic              err_reg;
  logic [7:0]        op_count_reg;

  // Instruction field split: {op, srcA, srcB, dst}
  logic [1:0]        instr_op;
  logic [ADDR_W-1:0] instr_src_a;
  logic [ADDR_W-1:0] instr_src_b;
  logic [ADDR_W-1:0] instr_dst;

  assign instr_op    = instr[3*ADDR_W+1 : 3*ADDR_W];
  assign instr_src_a = instr[3*ADDR_W-1 : 2*ADDR_W];
  assign instr_src_b = instr[2*ADDR_W-1 : ADDR_W];
  assign instr_dst   = instr[ADDR_W-1 : 0];

  // ---------------------------------------------------------------------
  // Datapath. Operands come straight off the read ports during EXEC, so
  // the result is ready to be registered at the end of that cycle.
  // ---------------------------------------------------------------------

  // Add/sub per nibble lane: lane 0 is the imaginary part, lane 1 the real.
  // Plain 4-bit arithmetic gives the required two's-complement wrap.
  logic [7:0] addsub_res;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [3:0] lane_a;
    logic [3:0] lane_b;
    assign lane_a = mem_rd_data1[gi*4 +: 4];
    assign lane_b = mem_rd_data2[gi*4 +: 4];
    assign addsub_res[gi*4 +: 4] = (op_reg == OP_SUB) ? (lane_a - lane_b)
                                                      : (lane_a + lane_b);
  end

  // Complex multiply on sign-extended operands; 10 bits holds every
  // intermediate sum (worst case +128), only the low nibble is kept.
  logic signed [9:0] ar_x;
  logic signed [9:0] ai_x;
  logic signed [9:0] br_x;
  logic signed [9:0] bi_x;
  logic signed [9:0] mul_re;
  logic signed [9:0] mul_im;

  assign ar_x   = {{6{mem_rd_data1[7]}}, mem_rd_data1[7:4]};
  assign ai_x   = {{6{mem_rd_data1[3]}}, mem_rd_data1[3:0]};
  assign br_x   = {{6{mem_rd_data2[7]}}, mem_rd_data2[7:4]};
  assign bi_x   = {{6{mem_rd_data2[3]}}, mem_rd_data2[3:0]};
  assign mul_re = (ar_x * br_x) - (ai_x * bi_x);
  assign mul_im = (ar_x * bi_x) + (ai_x * br_x);

  logic [7:0] exec_result;

  assign exec_result = (op_reg == OP_MUL) ? {mul_re[3:0], mul_im[3:0]}
                                          : addsub_res;

  // ---------------------------------------------------------------------
  // Output decode. Everything memory-facing depends only on the state
  // register and latched fields, so a reset forces it to zero at once.
  // ---------------------------------------------------------------------
  assign instr_ready  = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign mem_enable   = (state_reg == READ) || (state_reg == WRITE);
  assign mem_write    = (state_reg == WRITE);
  assign mem_rd_addr1 = mem_enable ? src_a_reg : '0;
  assign mem_rd_addr2 = mem_enable ? src_b_reg : '0;
  assign mem_wr_addr  = mem_write ? dst_reg : '0;
  assign mem_wr_data  = mem_write ? result_reg : 8'h00;
  assign err          = err_reg;
  assign result       = result_reg;
  assign op_count     = op_count_reg;

  // Control FSM: latch on handshake, step through read/exec/write/done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_ADD;
      src_a_reg    <= '0;
      src_b_reg    <= '0;
      dst_reg      <= '0;
      result_reg   <= 8'h00;
      err_reg      <= 1'b0;
      op_count_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            op_reg    <= instr_op;
            src_a_reg <= instr_src_a;
            src_b_reg <= instr_src_b;
            dst_reg   <= instr_dst;
            state_reg <= READ;
          end
        end
        READ: begin
          state_reg <= EXEC;
        end
        EXEC: begin
          if (op_reg == OP_RSV) begin
            // Reserved opcode: keep the previous result, flag it, no write
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            result_reg <= exec_result;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          op_count_reg <= op_count_reg + 8'd1;
          state_reg    <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_exec_ctrl.sv
// tb_complex_exec_ctrl: table-driven check of complex_exec_ctrl against a
// behavioural data memory, with a scoreboard of expected completions and
// hand-written sequences for reserved opcode, reset-in-EXEC and back-to-back.
module tb_complex_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [19:0] instr;
  logic        instr_ready;
  logic        mem_enable;
  logic        mem_write;
  logic [5:0]  mem_rd_addr1;
  logic [5:0]  mem_rd_addr2;
  logic [5:0]  mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data1;
  logic [7:0]  mem_rd_data2;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  result;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;

  complex_exec_ctrl #(.ADDR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .mem_enable   (mem_enable),
    .mem_write    (mem_write),
    .mem_rd_addr1 (mem_rd_addr1),
    .mem_rd_addr2 (mem_rd_addr2),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data1 (mem_rd_data1),
    .mem_rd_data2 (mem_rd_data2),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .result       (result),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with registered read and a bench preload port
  bit   [7:0] mem [64];
  logic       pre_we = 1'b0;
  logic [5:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_enable) begin
      mem_rd_data1 <= mem[mem_rd_addr1];
      mem_rd_data2 <= mem[mem_rd_addr2];
      if (mem_write) mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard entry: what a completion must look like
  typedef struct {
    logic [5:0] dst;
    logic [7:0] exp_mem;
    logic [7:0] exp_result;
    logic [7:0] exp_count;
    logic       exp_err;
    int         exp_lat;
    int         exp_wr;
  } sb_t;

  sb_t sb_q[$];

  // Bench-side model of the architectural registers
  logic [7:0] m_result = 8'h00;
  logic [7:0] m_count  = 8'h00;
  logic       m_err    = 1'b0;

  typedef struct {
    logic [1:0] op;
    logic [5:0] sa;
    logic [5:0] sb;
    logic [5:0] d;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] addr, input logic [7:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Update the model for an accepted instruction and push its expectation
  task automatic push_expect(input logic [1:0] op, input logic [5:0] d, input logic [7:0] exp_mem);
    sb_t e;
    if (op == 2'b11) begin
      m_err = 1'b1;
    end else begin
      m_result = exp_mem;
      m_count  = m_count + 8'd1;
    end
    e.dst        = d;
    e.exp_mem    = exp_mem;
    e.exp_result = m_result;
    e.exp_count  = m_count;
    e.exp_err    = m_err;
    e.exp_lat    = (op == 2'b11) ? 3 : 4;
    e.exp_wr     = (op == 2'b11) ? 0 : 1;
    sb_q.push_back(e);
  endtask

  // Issue one instruction, watch its window; latency counts the cycles
  // after the handshake edge, the first one (READ) being cycle 1.
  task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] sa,
                        input logic [5:0] sbb, input logic [5:0] d, input logic [7:0] exp_mem);
    sb_t e;
    int  lat;
    int  wr;
    bit  got;
    @(negedge clk);
    instr       = {op, sa, sbb, d};
    instr_valid = 1'b1;
    for (int t = 0; t < 20 && !instr_ready; t++) @(negedge clk);
    if (!instr_ready) begin
      errors++;
      checks++;
      $display("FAIL %s handshake: instr_ready never rose", name);
      instr_valid = 1'b0;
      return;
    end
    push_expect(op, d, exp_mem);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 0;
    wr  = 0;
    got = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_write) wr++;
      if (done && !got) begin
        got = 1'b1;
        lat = k;
      end
    end
    e = sb_q.pop_front();
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s done: no done pulse within 8 cycles", name);
    end else begin
      check({name, " latency"}, lat, e.exp_lat);
    end
    check({name, " writes"}, wr, e.exp_wr);
    check({name, " mem"}, mem[e.dst], e.exp_mem);
    check({name, " result"}, result, e.exp_result);
    check({name, " op_count"}, op_count, e.exp_count);
    check({name, " err"}, err, e.exp_err);
    $display("txn %s op=%0d dst=%0d mem=0x%02h lat=%0d op_count=%0d err=%0d",
             name, op, d, mem[e.dst], lat, op_count, err);
  endtask

  initial begin
    logic [19:0] bb_instr [3];
    logic [7:0]  bb_exp [3];
    logic [1:0]  bb_op [3];
    int          hs_cyc [3];
    int          n_hs;
    int          n_done;
    int          viol;
    bit          adv;
    sb_t         e;

    // Expected values are worked by hand from the nibble arithmetic
    vecs[0] = '{2'b00, 6'd0,  6'd1,  6'd2,  8'h31, 8'h23, 8'h54};
    vecs[1] = '{2'b01, 6'd12, 6'd13, 6'd14, 8'hBE, 8'h23, 8'h9B};
    vecs[2] = '{2'b10, 6'd15, 6'd16, 6'd17, 8'h22, 8'h21, 8'h26};
    vecs[3] = '{2'b10, 6'd18, 6'd19, 6'd20, 8'hD2, 8'hE1, 8'h49};
    vecs[4] = '{2'b00, 6'd21, 6'd22, 6'd23, 8'h70, 8'h10, 8'h80};
    vecs[5] = '{2'b01, 6'd24, 6'd25, 6'd26, 8'h80, 8'h10, 8'h70};
    vecs[6] = '{2'b10, 6'd27, 6'd28, 6'd29, 8'h87, 8'h87, 8'hF0};
    vecs[7] = '{2'b00, 6'd30, 6'd30, 6'd30, 8'h12, 8'h12, 8'h24};
    vecs[8] = '{2'b10, 6'd31, 6'd32, 6'd33, 8'h7F, 8'h11, 8'h86};

    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;

    // Reset state
    #12;
    check("reset instr_ready", instr_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset mem_enable", mem_enable, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset result", result, 8'h00);
    check("reset op_count", op_count, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].sa, vecs[i].a);
      preload(vecs[i].sb, vecs[i].b);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].d, vecs[i].exp);
    end

    // Reserved opcode: no write, shorter latency, sticky err
    preload(6'd42, 8'h5A);
    run_op("reserved", 2'b11, 6'd40, 6'd41, 6'd42, 8'h5A);
    preload(6'd43, 8'h11);
    preload(6'd44, 8'h11);
    run_op("after_rsv", 2'b00, 6'd43, 6'd44, 6'd45, 8'h22);

    // Back-to-back with instr_valid held high
    bb_op[0] = 2'b00; bb_instr[0] = {2'b00, 6'd0,  6'd1,  6'd34}; bb_exp[0] = 8'h54;
    bb_op[1] = 2'b01; bb_instr[1] = {2'b01, 6'd12, 6'd13, 6'd35}; bb_exp[1] = 8'h9B;
    bb_op[2] = 2'b10; bb_instr[2] = {2'b10, 6'd15, 6'd16, 6'd36}; bb_exp[2] = 8'h26;
    n_hs   = 0;
    n_done = 0;
    viol   = 0;
    adv    = 1'b0;
    @(negedge clk);
    instr       = bb_instr[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 60 && n_done < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (n_hs < 3) instr = bb_instr[n_hs];
        else instr_valid = 1'b0;
      end
      if (instr_ready && busy) viol++;
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("b2b%0d mem", n_done), mem[e.dst], e.exp_mem);
        $display("txn b2b%0d dst=%0d mem=0x%02h cycle=%0d", n_done, e.dst, mem[e.dst], c);
        n_done++;
      end
      if (instr_valid && instr_ready && n_hs < 3) begin
        hs_cyc[n_hs] = c;
        push_expect(bb_op[n_hs], bb_instr[n_hs][5:0], bb_exp[n_hs]);
        n_hs++;
        adv = 1'b1;
      end
    end
    instr_valid = 1'b0;
    check("b2b completions", n_done, 3);
    check("b2b handshakes", n_hs, 3);
    if (n_hs == 3) begin
      check("b2b gap01", hs_cyc[1] - hs_cyc[0], 5);
      check("b2b gap12", hs_cyc[2] - hs_cyc[1], 5);
    end
    check("b2b ready_while_busy", viol, 0);
    check("b2b op_count", op_count, m_count);

    // Reset asserted while in EXEC
    preload(6'd48, 8'h11);
    preload(6'd49, 8'h11);
    preload(6'd50, 8'hAA);
    @(negedge clk);
    instr       = {2'b00, 6'd48, 6'd49, 6'd50};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("exec busy", busy, 1'b1);
    check("exec mem_enable", mem_enable, 1'b0);
    rst = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst outputs", {mem_enable, mem_write, done, err, mem_rd_addr1, mem_rd_addr2,
                          mem_wr_addr, mem_wr_data}, 32'h0);
    check("rst result", result, 8'h00);
    check("rst op_count", op_count, 8'h00);
    $display("txn reset_in_exec busy=%0d result=0x%02h op_count=%0d", busy, result, op_count);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst target unwritten", mem[50], 8'hAA);
    m_count  = 8'h00;
    m_result = 8'h00;
    m_err    = 1'b0;
    run_op("after_reset", 2'b00, 6'd48, 6'd49, 6'd51, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
